seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Parametrised time-multiplexed driver for common-anode 7-segment displays. It takes a packed BCD digit vector from the service blocks (time set, alarm set, stopwatch) and scans one digit per slot onto shared `eSeg`/`anode` pins. Per-digit decimal points, explicit blanking, leading-zero suppression and optional blinking are supported. Digit data are snapshotted once per frame to prevent tearing.

## Interface
Parameters:
- `NUM_DIGITS`, 4: number of digits scanned (≥2).
- `SCAN_DIV`, 100000: `clk_osc` cycles each digit stays lit (≥2).
- `BLINK_FRAMES`, 64: frames per blink half-period (≥1); used only with `SEG_BLINK_EN`.

Ports (one clock; reset is asynchronous and active-high):
- `clk_osc`  in  1  board oscillator clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  1 = scan; 0 = display dark, counters hold.
- `digits`  in  4*NUM_DIGITS  BCD digits; `digits[3:0]` = digit 0 = rightmost.
- `dp_mask`  in  NUM_DIGITS  1 = decimal point lit on that digit.
- `blank_mask`  in  NUM_DIGITS  1 = force digit dark, including its dp.
- `blink_mask`  in  NUM_DIGITS  1 = digit blinks.
- `lz_blank`  in  1  1 = suppress leading zeros.
- `anode`  out  NUM_DIGITS  active-low digit enables; `anode[i]` drives digit i.
- `eSeg`  out  8  `{dp,g,f,e,d,c,b,a}`, active-high.
- `digit_idx`  out  $clog2(NUM_DIGITS)  index of the digit currently shown on the outputs.
- `frame_tick`  out  1  one-cycle pulse when the index wraps to 0.

## Operation
- Prescaler `pre` counts 0..SCAN_DIV-1. When it reaches its terminal count, it wraps to 0 and `idx` advances. `idx` wraps from NUM_DIGITS-1 to 0.
- Snapshot registers (`digits`, `dp_mask`, `blank_mask`, `blink_mask`, `lz_blank`):
  - Loaded on the edge where `idx` wraps to 0.
  - Also loaded on the first edge after reset deasserts.
  - Input changes mid-frame are not visible until the next frame.
- Decode: BCD 0–9 map to the codebase segment patterns (0 = 7'b0111111 … 9 = 7'b1101111). Codes 10–15 give segments 0000000.
- Leading-zero suppression (snapshot `lz_blank`=1):
  - Scanning from digit NUM_DIGITS-1 downward, every digit whose value is 0 and has only zeros above it is dark.
  - Digit 0 is never suppressed.
  - A dp on a suppressed digit remains lit.
- Priority per digit, highest first: `enable`=0 → blank_mask → blink-off phase → leading-zero → normal.
- Output register update every edge:
  - `anode` ← one-cold(`idx`).
  - `eSeg` ← pattern of snapshot digit `idx`.
  - `digit_idx` ← `idx`.
- A dark digit keeps its anode asserted with `eSeg`=0.
- `enable`=0: `anode` all 1, `eSeg`=0, `frame_tick`=0. `pre`, `idx` and the blink counters hold their values, and resume exactly where they stopped when `enable` returns to 1.
- `frame_tick` = 1 in the cycle after the edge where `idx` wraps to 0 (aligned with digit 0 appearing on the outputs).

## Timing
- Reset values:
  - `anode` = all 1, `eSeg` = 0, `digit_idx` = 0, `frame_tick` = 0.
  - `pre` = 0, `idx` = 0, snapshot = 0, blink phase = visible.
- Latency: outputs lag `idx` by exactly 1 cycle. A new input value appears on the outputs at most 1 frame + 1 cycle after it is applied.
- Each digit is lit for exactly SCAN_DIV cycles. Frame period = NUM_DIGITS*SCAN_DIV cycles.
- Reset asserted mid-scan: all registers take their reset values immediately, with no clock needed.
- Reset release: the first edge loads the snapshot and drives digit 0.

## Configuration
- `SEG_BLINK_EN` defined:
  - A frame counter toggles the blink phase every BLINK_FRAMES frames.
  - While the phase is off, digits with snapshot `blink_mask`=1 are dark.
  - The counter holds while `enable`=0.
- `SEG_BLINK_EN` undefined: the blink counter is not built, `blink_mask` is ignored, and all other behaviour is identical.

## Structure
- Shared package `seg_pkg`: the BCD→segment pattern constants, the blank pattern, and the `eSeg` bit-position constants (DP=7, G=6 … A=0).
- One sub-module, `seg_decode`: combinational 4-bit BCD → 7-bit pattern, instantiated once on the selected digit.

## Test plan
Bench parameters: NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
- Reset scan: assert reset, apply `digits`=16'h1234, release reset → `anode` cycles 1110,1101,1011,0111, each held 4 cycles. `eSeg` shows 4,3,2,1 patterns. `frame_tick` pulses every 16 cycles.
- Tearing: change `digits` to 16'h5678 while digit 1 is shown → the current frame still shows 1234; the next frame shows 5678.
- Leading zeros and blanking: `digits`=16'h0005, `lz_blank`=1 → digits 3–1 show `eSeg`=0 and digit 0 shows 5. Then `digits`=16'h0000 → only digit 0 shows 0. Then `blank_mask`=4'b0001 → digit 0 is also dark.
- Decimal point and invalid code: `digits`=16'h00A0, `dp_mask`=4'b0100 → digit 1 `eSeg`=8'h00; digit 2 `eSeg`=8'hBF (0 pattern with dp lit).
- Enable and reset mid-scan: drop `enable` during digit 2 → `anode`=4'hF and `eSeg`=0. Re-enable → digit 2 resumes with its remaining count. Assert reset mid-digit → outputs reach their reset values with no clock edge.
- Blink, with `SEG_BLINK_EN` defined: `blink_mask`=4'b1000 → digit 3 is dark for 2 frames and lit for 2 frames, repeating. With the macro undefined, digit 3 is always lit.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared segment-pattern constants for the 7-segment scan driver.
// Latency: n/a (constants only). Backpressure: none.
package seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Patterns are {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_PAT_0 = 7'b0111111;
  localparam logic [6:0] SEG_PAT_1 = 7'b0000110;
  localparam logic [6:0] SEG_PAT_2 = 7'b1011011;
  localparam logic [6:0] SEG_PAT_3 = 7'b1001111;
  localparam logic [6:0] SEG_PAT_4 = 7'b1100110;
  localparam logic [6:0] SEG_PAT_5 = 7'b1101101;
  localparam logic [6:0] SEG_PAT_6 = 7'b1111101;
  localparam logic [6:0] SEG_PAT_7 = 7'b0000111;
  localparam logic [6:0] SEG_PAT_8 = 7'b1111111;
  localparam logic [6:0] SEG_PAT_9 = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg_decode.sv
// Combinational BCD to 7-segment pattern; codes 10-15 decode dark.
// Latency: 0 cycles. Backpressure: none.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_PAT_0;
      4'd1: seg = SEG_PAT_1;
      4'd2: seg = SEG_PAT_2;
      4'd3: seg = SEG_PAT_3;
      4'd4: seg = SEG_PAT_4;
      4'd5: seg = SEG_PAT_5;
      4'd6: seg = SEG_PAT_6;
      4'd7: seg = SEG_PAT_7;
      4'd8: seg = SEG_PAT_8;
      4'd9: seg = SEG_PAT_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with per-frame input snapshot; SEG_BLINK_EN adds blinking.
// Latency: outputs lag the scan index by 1 cycle. Backpressure: none; enable=0 darkens and freezes the scan.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                          clk_osc,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [4*NUM_DIGITS-1:0]       digits,
  input  logic [NUM_DIGITS-1:0]         dp_mask,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  input  logic                          lz_blank,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [7:0]                    eSeg,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = $clog2(SCAN_DIV);

  logic [PRE_W-1:0]        pre;
  logic [IDX_W-1:0]        idx;
  logic                    first;
  logic                    wrap_pend;
  logic                    pre_tc;
  logic                    wrap;
  logic                    blink_off;

  logic [4*NUM_DIGITS-1:0] snap_dig, cur_dig;
  logic [NUM_DIGITS-1:0]   snap_dp, cur_dp;
  logic [NUM_DIGITS-1:0]   snap_blank, cur_blank;
  logic [NUM_DIGITS-1:0]   snap_blink, cur_blink;
  logic                    snap_lz, cur_lz;

  logic [NUM_DIGITS-1:0]   lz_dark;
  logic                    above_zero;
  logic [3:0]              sel_bcd;
  logic [6:0]              sel_seg;
  logic [NUM_DIGITS-1:0]   anode_d;
  logic [7:0]              seg_d;

  assign pre_tc = (pre == PRE_W'(SCAN_DIV - 1));
  assign wrap   = enable && pre_tc && (idx == IDX_W'(NUM_DIGITS - 1));

  // The first edge after reset shows digit 0 of the live inputs it is loading.
  assign cur_dig   = first ? digits     : snap_dig;
  assign cur_dp    = first ? dp_mask    : snap_dp;
  assign cur_blank = first ? blank_mask : snap_blank;
  assign cur_blink = first ? blink_mask : snap_blink;
  assign cur_lz    = first ? lz_blank   : snap_lz;

  always_comb begin
    above_zero = 1'b1;
    lz_dark    = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      above_zero = above_zero && (cur_dig[i*4 +: 4] == 4'd0);
      lz_dark[i] = cur_lz && above_zero;
    end
  end

  assign sel_bcd = cur_dig[int'(idx)*4 +: 4];

  seg_decode u_decode (
    .bcd (sel_bcd),
    .seg (sel_seg)
  );

  always_comb begin
    anode_d = '1;
    seg_d   = 8'h00;
    if (enable) begin
      anode_d = ~(NUM_DIGITS'(1) << idx);
      if (!cur_blank[idx] && !(blink_off && cur_blink[idx])) begin
        // Leading-zero suppression darkens segments only; the dp stays lit.
        seg_d[SEG_DP] = cur_dp[idx];
        if (!lz_dark[idx]) seg_d[SEG_G:SEG_A] = sel_seg;
      end
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BF_W-1:0] blink_cnt;

  always_ff @(posedge clk_osc or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (wrap) begin
      if (blink_cnt == BF_W'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        blink_cnt <= blink_cnt + BF_W'(1);
      end
    end
  end
`else
  // Constant visible; BLINK_FRAMES is at least 1 so this is always 0.
  assign blink_off = (BLINK_FRAMES < 1);
`endif

  always_ff @(posedge clk_osc or posedge reset) begin
    if (reset) begin
      pre        <= '0;
      idx        <= '0;
      first      <= 1'b1;
      wrap_pend  <= 1'b0;
      snap_dig   <= '0;
      snap_dp    <= '0;
      snap_blank <= '0;
      snap_blink <= '0;
      snap_lz    <= 1'b0;
      anode      <= '1;
      eSeg       <= 8'h00;
      digit_idx  <= '0;
      frame_tick <= 1'b0;
    end else begin
      first <= 1'b0;
      if (first || wrap) begin
        snap_dig   <= digits;
        snap_dp    <= dp_mask;
        snap_blank <= blank_mask;
        snap_blink <= blink_mask;
        snap_lz    <= lz_blank;
      end
      if (enable) begin
        wrap_pend <= wrap;
        if (pre_tc) begin
          pre <= '0;
          idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
          pre <= pre + PRE_W'(1);
        end
      end
      anode      <= anode_d;
      eSeg       <= seg_d;
      digit_idx  <= idx;
      // A wrap seen just before a disable is held so the tick marks digit 0 on resume.
      frame_tick <= enable && wrap_pend;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed plus randomized bench for seg_scan_driver against a frame-arithmetic reference model.
module tb_seg_scan_driver;

  localparam int N     = 4;
  localparam int SD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = N * SD;

  logic        clk_osc = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp_mask = '0;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  blink_mask = '0;
  logic        lz_blank = 1'b0;
  logic [3:0]  anode;
  logic [7:0]  eSeg;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  // Reference state: enabled edges since reset release, pending first edge, frame snapshot.
  int          e;
  bit          first;
  logic [15:0] s_dig;
  logic [3:0]  s_dp, s_blank, s_blink;
  logic        s_lz;

  logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

  seg_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk_osc    (clk_osc),
    .reset      (reset),
    .enable     (enable),
    .digits     (digits),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .lz_blank   (lz_blank),
    .anode      (anode),
    .eSeg       (eSeg),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  always #5 clk_osc = ~clk_osc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h (e=%0d)", tag, got, exp, e);
    end
  endtask

  function automatic logic [7:0] model_seg(input logic [15:0] dg, input logic [3:0] dp,
                                           input logic [3:0] bl, input logic [3:0] bk,
                                           input logic lz, input int i, input bit off);
    logic [7:0] r;
    bit leading;
    int v;
    v = int'(dg[i*4 +: 4]);
    leading = 1'b1;
    for (int j = i; j < N; j++)
      if (dg[j*4 +: 4] != 4'd0) leading = 1'b0;
    if (bl[i] || (off && bk[i])) return 8'h00;
    r = {dp[i], pat[v]};
    if (lz && leading && i != 0) r[6:0] = 7'h00;
    return r;
  endfunction

  task automatic model_reset();
    e = 0;
    first = 1'b1;
    s_dig = '0; s_dp = '0; s_blank = '0; s_blink = '0; s_lz = 1'b0;
  endtask

  task automatic cycle();
    int di;
    bit off, load;
    logic [3:0] ea;
    logic [7:0] es;
    logic et;
    di = (e / SD) % N;
`ifdef SEG_BLINK_EN
    off = (((e / FRAME) / BF) % 2) == 1;
`else
    off = 1'b0;
`endif
    ea = enable ? ~(4'b0001 << di) : 4'hF;
    if (!enable) es = 8'h00;
    else if (first) es = model_seg(digits, dp_mask, blank_mask, blink_mask, lz_blank, di, off);
    else es = model_seg(s_dig, s_dp, s_blank, s_blink, s_lz, di, off);
    et = enable && (e > 0) && (e % FRAME == 0);
    load = first || (enable && ((e + 1) % FRAME == 0));
    @(posedge clk_osc);
    #1;
    if (load) begin
      s_dig = digits; s_dp = dp_mask; s_blank = blank_mask; s_blink = blink_mask; s_lz = lz_blank;
    end
    first = 1'b0;
    if (enable) e++;
    chk("anode", 32'(anode), 32'(ea));
    chk("eSeg", 32'(eSeg), 32'(es));
    chk("digit_idx", 32'(digit_idx), 32'(di));
    chk("frame_tick", 32'(frame_tick), 32'(et));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_anode"}, 32'(anode), 32'hF);
    chk({tag, "_eSeg"}, 32'(eSeg), 32'h0);
    chk({tag, "_idx"}, 32'(digit_idx), 32'h0);
    chk({tag, "_tick"}, 32'(frame_tick), 32'h0);
  endtask

  initial begin
    model_reset();
    digits = 16'h1234;
    enable = 1'b1;
    #12;
    chk_reset_vals("rst");
    @(posedge clk_osc);
    #1;
    reset = 1'b0;
    model_reset();
    repeat (2 * FRAME + 4) cycle();

    // Tearing: change mid-frame while digit 1 is lit.
    while (((e / SD) % N) != 1) cycle();
    digits = 16'h5678;
    repeat (2 * FRAME) cycle();

    // Leading zeros, all-zero, then explicit blank on digit 0.
    digits = 16'h0005; lz_blank = 1'b1;
    repeat (2 * FRAME) cycle();
    digits = 16'h0000;
    repeat (2 * FRAME) cycle();
    blank_mask = 4'b0001;
    repeat (2 * FRAME) cycle();

    // Decimal point on a zero digit and an invalid code.
    blank_mask = 4'b0000; lz_blank = 1'b0;
    digits = 16'h00A0; dp_mask = 4'b0100;
    repeat (2 * FRAME) cycle();

    // Disable during digit 2, then resume.
    digits = 16'h1234; dp_mask = 4'b0000;
    while (((e / SD) % N) != 2) cycle();
    cycle();
    enable = 1'b0;
    repeat (5) cycle();
    enable = 1'b1;
    repeat (2 * FRAME) cycle();

    // Blink on digit 3.
    blink_mask = 4'b1000;
    repeat (6 * FRAME) cycle();

    // Randomized inputs and enable gaps.
    repeat (60) begin
      for (int k = 0; k < N; k++)
        digits[k*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'(0) : 4'($urandom_range(0, 15));
      dp_mask    = 4'($urandom);
      blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      blink_mask = 4'($urandom);
      lz_blank   = 1'($urandom);
      enable     = ($urandom_range(0, 5) != 0);
      repeat ($urandom_range(1, 20)) cycle();
    end

    // Reset asserted mid-digit must clear outputs without a clock edge.
    enable = 1'b1;
    repeat (3) cycle();
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(posedge clk_osc);
    #1;
    reset = 1'b0;
    model_reset();
    repeat (2 * FRAME) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
